// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared IEEE-754 single-precision types, constants and special-operand helpers
package fpu_pkg;

    localparam int          EXP_W   = 8;
    localparam int          FRAC_W  = 23;
    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} fdiv_state_t;

    function automatic logic is_nan(fp32_t v);
        return (v.exp == '1) && (v.frac != '0);
    endfunction

    function automatic logic is_inf(fp32_t v);
        return (v.exp == '1) && (v.frac == '0);
    endfunction

    // Denormals have exp 0 and are flushed, so they count as zero
    function automatic logic is_zero(fp32_t v);
        return v.exp == '0;
    endfunction

    function automatic logic is_special(fp32_t a, fp32_t b);
        return (a.exp == '0) || (b.exp == '0) || (a.exp == '1) || (b.exp == '1);
    endfunction

    function automatic logic [31:0] special_result(fp32_t a, fp32_t b);
        logic s;
        s = a.sign ^ b.sign;
        if (is_nan(a) || is_nan(b))         return QNAN;
        else if (is_zero(a) && is_zero(b))  return QNAN;
        else if (is_inf(a) && is_inf(b))    return QNAN;
        else if (is_zero(b) || is_inf(a))   return POS_INF | {s, 31'b0};
        else                                return {s, 31'b0};
    endfunction

endpackage

// File: rtl/fdiv_round.sv
// rtl/fdiv_round.sv - combinational normalise, round-to-nearest-even, range clamp and pack
module fdiv_round #(
    parameter int W = 26
) (
    input  logic               sign_i,
    input  logic signed [9:0]  exp_i,
    input  logic [W-1:0]       quo_i,
    input  logic               sticky_i,
    output logic [31:0]        y_o
);

    logic [W-1:0]       nq;
    logic signed [9:0]  e_norm;
    logic signed [9:0]  e_rnd;
    logic [23:0]        mant;
    logic               guard;
    logic               sticky;
    logic               rnd_up;
    logic [24:0]        mant_r;
    logic [22:0]        frac;

    always_comb begin
        nq     = quo_i[W-1] ? quo_i : quo_i << 1;
        e_norm = quo_i[W-1] ? exp_i : exp_i - 10'sd1;
        mant   = nq[W-1 -: 24];
        guard  = nq[W-25];
        sticky = sticky_i | (|nq[W-26:0]);
        rnd_up = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'b0, rnd_up};
        // Carry out of the mantissa means 1.111..1 rounded up to 10.000..0
        e_rnd  = mant_r[24] ? e_norm + 10'sd1 : e_norm;
        frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        if (e_rnd >= 10'sd255)
            y_o = {sign_i, 8'hFF, 23'b0};
        else if (e_rnd <= 10'sd0)
            y_o = {sign_i, 31'b0};
        else
            y_o = {sign_i, e_rnd[7:0], frac};
    end

endmodule

// File: rtl/fdiv_iter.sv
// rtl/fdiv_iter.sv - iterative restoring FP32 divider; FDIV_EARLY_EXIT_EN lets special operands bypass DIV/NORM
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        busy,
    output logic        done,
    output logic [31:0] y
);

    localparam int             CW   = $clog2(QBITS);
    localparam logic [CW-1:0]  LAST = CW'(QBITS - 1);

    fdiv_state_t        state_q;
    logic [CW-1:0]      cnt_q;
    logic [24:0]        rem_q;
    logic [23:0]        dvs_q;
    logic [QBITS-1:0]   quo_q;
    logic signed [9:0]  exp_q;
    logic               sign_q;
    logic               spec_q;
    logic [31:0]        spec_y_q;
    logic [31:0]        y_q;
    logic               busy_q;
    logic               done_q;

    fp32_t              a;
    fp32_t              b;
    logic signed [9:0]  exp_d;
    logic [25:0]        diff;
    logic               qbit;
    logic [31:0]        round_y;

    assign a     = x1;
    assign b     = x2;
    assign exp_d = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp}) + 10'(BIAS);
    // Trial subtract: a non-negative difference means the quotient bit is 1
    assign diff  = {1'b0, rem_q} - {2'b00, dvs_q};
    assign qbit  = ~diff[25];

    fdiv_round #(.W(QBITS)) u_round (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .quo_i    (quo_q),
        .sticky_i (|rem_q),
        .y_o      (round_y)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            spec_q   <= 1'b0;
            spec_y_q <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sign_q   <= a.sign ^ b.sign;
                        exp_q    <= exp_d;
                        rem_q    <= {2'b01, a.frac};
                        dvs_q    <= {1'b1, b.frac};
                        quo_q    <= '0;
                        cnt_q    <= '0;
                        spec_q   <= is_special(a, b);
                        spec_y_q <= special_result(a, b);
`ifdef FDIV_EARLY_EXIT_EN
                        if (is_special(a, b)) begin
                            y_q     <= special_result(a, b);
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= DIV;
                        end
`else
                        busy_q  <= 1'b1;
                        state_q <= DIV;
`endif
                    end
                end
                DIV: begin
                    quo_q <= {quo_q[QBITS-2:0], qbit};
                    rem_q <= (qbit ? diff[24:0] : rem_q) << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST)
                        state_q <= NORM;
                end
                NORM: begin
                    y_q     <= spec_q ? spec_y_q : round_y;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// tb/tb_fdiv_iter.sv - directed and random self-checking bench for fdiv_iter
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;

    localparam int LAT = 28;
`ifdef FDIV_EARLY_EXIT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 28;
`endif

    always #5 clk = ~clk;

    fdiv_iter dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .x1    (x1),
        .x2    (x2),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    // Independent reference: one exact integer division plus explicit remainder-based RNE
    function automatic logic [31:0] gold(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e;
        logic   na, nb, ia, ib, za, zb;
        longint ma, mb, q, r;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        za = (ea == 0);
        zb = (eb == 0);
        if (na || nb)     return 32'h7FC0_0000;
        if (za && zb)     return 32'h7FC0_0000;
        if (ia && ib)     return 32'h7FC0_0000;
        if (zb || ia)     return {s, 8'hFF, 23'h0};
        if (za || ib)     return {s, 31'h0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        e  = ea - eb + 127;
        if (ma < mb) begin
            ma = ma * 2;
            e  = e - 1;
        end
        q = (ma << 23) / mb;
        r = (ma << 23) % mb;
        if ((2 * r > mb) || ((2 * r == mb) && q[0]))
            q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0)   return {s, 31'h0};
        return {s, e[7:0], q[22:0]};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] yo, output int lat);
        @(negedge clk);
        x1 = a;
        x2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        yo = y;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h exp 00000000", y); end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        int          bad_busy;
        int          done_cyc;
        int          lat;
        logic [31:0] r;
        @(negedge clk);
        x1 = 32'h3F80_0000;
        x2 = 32'h3F80_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad_busy = 0;
        done_cyc = -1;
        for (int c = 1; c <= LAT; c++) begin
            if (c > 1) @(negedge clk);
            if (busy !== (c < LAT)) bad_busy++;
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        checks++; if (done_cyc != LAT) begin errors++; $display("FAIL one_done_cycle got %0d exp %0d", done_cyc, LAT); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL one_busy_window got %0d bad cycles exp 0", bad_busy); end
        checks++; if (y !== 32'h3F80_0000) begin errors++; $display("FAIL one_over_one got %h exp 3f800000", y); end
        do_op(32'h3F80_0000, 32'h4040_0000, r, lat);
        checks++; if (r !== 32'h3EAA_AAAB) begin errors++; $display("FAIL one_third got %h exp 3eaaaaab", r); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL one_third_lat got %0d exp %0d", lat, LAT); end
        do_op(32'h40C0_0000, 32'h4000_0000, r, lat);
        checks++; if (r !== 32'h4040_0000) begin errors++; $display("FAIL six_over_two got %h exp 40400000", r); end
    endtask

    task automatic test_specials();
        logic [31:0] va [0:6];
        logic [31:0] vb [0:6];
        logic [31:0] ve [0:6];
        logic [31:0] r;
        int          lat;
        va = '{32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000, 32'hFFC0_0001, 32'h7F80_0000, 32'h0000_0000, 32'hFF80_0000};
        vb = '{32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'hC000_0000, 32'h3F80_0000};
        ve = '{32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h8000_0000, 32'hFF80_0000};
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], r, lat);
            checks++; if (r !== ve[i]) begin errors++; $display("FAIL special_%0d got %h exp %h", i, r, ve[i]); end
            checks++; if (lat != SPEC_LAT) begin errors++; $display("FAIL special_lat_%0d got %0d exp %0d", i, lat, SPEC_LAT); end
        end
    endtask

    task automatic test_range();
        logic [31:0] r;
        int          lat;
        do_op(32'h7F7F_FFFF, 32'h3F00_0000, r, lat);
        checks++; if (r !== 32'h7F80_0000) begin errors++; $display("FAIL overflow got %h exp 7f800000", r); end
        do_op(32'h0080_0000, 32'h4000_0000, r, lat);
        checks++; if (r !== 32'h0000_0000) begin errors++; $display("FAIL underflow got %h exp 00000000", r); end
    endtask

    task automatic test_back_to_back();
        int          first_done;
        int          second_done;
        logic [31:0] y1;
        logic [31:0] y2;
        @(negedge clk);
        x1 = 32'h40C0_0000;
        x2 = 32'h4000_0000;
        start = 1'b1;
        first_done = -1;
        second_done = -1;
        y1 = '0;
        y2 = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (first_done < 0) begin first_done = c; y1 = y; end
                else if (second_done < 0) begin second_done = c; y2 = y; end
            end
            if (c == 5 || c == 27 || c == 29) begin
                x1 = 32'h3F80_0000;
                x2 = 32'h4040_0000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (first_done != 28) begin errors++; $display("FAIL b2b_first_cycle got %0d exp 28", first_done); end
        checks++; if (y1 !== 32'h4040_0000) begin errors++; $display("FAIL b2b_first_y got %h exp 40400000", y1); end
        checks++; if (second_done != 57) begin errors++; $display("FAIL b2b_second_cycle got %0d exp 57", second_done); end
        checks++; if (y2 !== 32'h3EAA_AAAB) begin errors++; $display("FAIL b2b_second_y got %h exp 3eaaaaab", y2); end
    endtask

    task automatic test_reset_mid();
        int          seen_done;
        logic [31:0] r;
        int          lat;
        @(negedge clk);
        x1 = 32'h3F80_0000;
        x2 = 32'h4040_0000;
        start = 1'b1;
        seen_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) seen_done++;
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL midrst_y got %h exp 00000000", y); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses exp 0", seen_done); end
        do_op(32'h40C0_0000, 32'h4000_0000, r, lat);
        checks++; if (r !== 32'h4040_0000) begin errors++; $display("FAIL midrst_after got %h exp 40400000", r); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL midrst_after_lat got %0d exp %0d", lat, LAT); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] e;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            if (i % 8 == 7) begin
                a = $urandom;
                b = $urandom;
            end else if (i % 8 == 6) begin
                a = {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
                b = {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
            end else begin
                a = {1'($urandom), 8'($urandom_range(160, 95)), 23'($urandom)};
                b = {1'($urandom), 8'($urandom_range(160, 95)), 23'($urandom)};
            end
            e = gold(a, b);
            do_op(a, b, r, lat);
            checks++;
            if (lat >= 100) begin
                errors++;
                $display("FAIL random_timeout %h/%h got no done exp done", a, b);
            end else if (r !== e) begin
                errors++;
                $display("FAIL random %h/%h got %h exp %h", a, b, r, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
